// File: rtl/key_entry_assembler.sv
// Keypad consumer: takes key events over the KeyRdy/KeyRd handshake, builds two
// signed decimal operands plus an operator, then holds a request to the ALU stage.
module key_entry_assembler #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        KeyRdy,
  output logic        KeyRd,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        calc_req,
  input  logic        calc_ack,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [2:0]  calc_op,
  output logic [15:0] display_value,
  output logic        err,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_hs_state
);

  // Handshake: KeyRdy is sampled only in H_IDLE; KeyRd is high for exactly the
  // cycle after the sampling edge; the next event is taken only after KeyRdy drops.
  typedef enum logic [1:0] {S_ENTER_A = 2'd0, S_ENTER_B = 2'd1, S_REQ = 2'd2, S_ERR = 2'd3} state_t;
  typedef enum logic [1:0] {H_IDLE = 2'd0, H_ACK = 2'd1, H_WAIT = 2'd2} hs_t;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b111;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_DIGITS);

  state_t st, st_nxt;
  hs_t    hs, hs_nxt;
  logic [16:0] mag_a, mag_b, mag_a_nxt, mag_b_nxt;
  logic        neg_a, neg_b, neg_a_nxt, neg_b_nxt;
  logic [3:0]  cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic [15:0] op_a_nxt, op_b_nxt;
  logic [2:0]  calc_op_nxt;
  logic        take, clr_entry;
  logic        is_dig, is_clear, is_arith, dig_ok;
  logic [19:0] new_a, new_b, lim_a, lim_b;

  function automatic logic [15:0] to_operand(input logic neg, input logic [16:0] mag);
    logic [16:0] t;
    t = neg ? (~mag + 17'd1) : mag;
    return t[15:0];
  endfunction

  assign is_dig   = !equal_input && (operator_input == 3'b000);
  assign is_clear = !equal_input && (operator_input == OP_CLEAR);
  assign is_arith = !equal_input && ((operator_input == OP_ADD) ||
                    (operator_input == OP_SUB) || (operator_input == OP_MUL));
  assign dig_ok   = (keypad_input <= 4'd9);
  // 20 bits hold worst case 32768*10+9 before the range check
  assign new_a = {3'b000, mag_a} * 20'd10 + {16'h0000, keypad_input};
  assign new_b = {3'b000, mag_b} * 20'd10 + {16'h0000, keypad_input};
  assign lim_a = neg_a ? 20'd32768 : 20'd32767;
  assign lim_b = neg_b ? 20'd32768 : 20'd32767;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      st        <= S_ENTER_A;
      hs        <= H_IDLE;
      mag_a     <= '0;
      mag_b     <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      operand_a <= '0;
      operand_b <= '0;
      calc_op   <= '0;
    end else begin
      st        <= st_nxt;
      hs        <= hs_nxt;
      mag_a     <= mag_a_nxt;
      mag_b     <= mag_b_nxt;
      neg_a     <= neg_a_nxt;
      neg_b     <= neg_b_nxt;
      cnt_a     <= cnt_a_nxt;
      cnt_b     <= cnt_b_nxt;
      operand_a <= op_a_nxt;
      operand_b <= op_b_nxt;
      calc_op   <= calc_op_nxt;
    end
  end

  always_comb begin
    hs_nxt      = hs;
    st_nxt      = st;
    mag_a_nxt   = mag_a;
    mag_b_nxt   = mag_b;
    neg_a_nxt   = neg_a;
    neg_b_nxt   = neg_b;
    cnt_a_nxt   = cnt_a;
    cnt_b_nxt   = cnt_b;
    op_a_nxt    = operand_a;
    op_b_nxt    = operand_b;
    calc_op_nxt = calc_op;
    take        = 1'b0;
    clr_entry   = 1'b0;

    case (hs)
      H_IDLE: if (KeyRdy && st != S_REQ) begin
        take   = 1'b1;
        hs_nxt = H_ACK;
      end
      H_ACK:   hs_nxt = H_WAIT;
      H_WAIT:  if (!KeyRdy) hs_nxt = H_IDLE;
      default: hs_nxt = H_IDLE;
    endcase

    if (st == S_REQ) begin
      if (calc_ack) begin
        st_nxt    = S_ENTER_A;
        clr_entry = 1'b1;
      end
    end else if (take) begin
      if (is_clear) begin
        st_nxt      = S_ENTER_A;
        calc_op_nxt = '0;
        clr_entry   = 1'b1;
      end else begin
        case (st)
          S_ENTER_A: begin
            if (is_dig && dig_ok && cnt_a != MAX_CNT) begin
              if (new_a > lim_a) st_nxt = S_ERR;
              else begin
                mag_a_nxt = new_a[16:0];
                cnt_a_nxt = cnt_a + 4'd1;
                op_a_nxt  = to_operand(neg_a, new_a[16:0]);
              end
            end else if (is_arith) begin
              if (cnt_a != 4'd0) begin
                calc_op_nxt = operator_input;
                st_nxt      = S_ENTER_B;
              end else if (operator_input == OP_SUB) begin
                neg_a_nxt = ~neg_a;
                op_a_nxt  = to_operand(~neg_a, mag_a);
              end
            end
          end
          S_ENTER_B: begin
            if (is_dig && dig_ok && cnt_b != MAX_CNT) begin
              if (new_b > lim_b) st_nxt = S_ERR;
              else begin
                mag_b_nxt = new_b[16:0];
                cnt_b_nxt = cnt_b + 4'd1;
                op_b_nxt  = to_operand(neg_b, new_b[16:0]);
              end
            end else if (equal_input) begin
              if (cnt_b != 4'd0) st_nxt = S_REQ;
            end else if (is_arith && cnt_b == 4'd0) begin
              if (operator_input == OP_SUB) begin
                neg_b_nxt = ~neg_b;
                op_b_nxt  = to_operand(~neg_b, mag_b);
              end else calc_op_nxt = operator_input;
            end
          end
          default: ;
        endcase
      end
    end

    if (clr_entry) begin
      mag_a_nxt = '0;
      mag_b_nxt = '0;
      neg_a_nxt = 1'b0;
      neg_b_nxt = 1'b0;
      cnt_a_nxt = '0;
      cnt_b_nxt = '0;
      op_a_nxt  = '0;
      op_b_nxt  = '0;
    end
  end

  // Decoded from state registers so an asynchronous reset drops them at once
  assign KeyRd        = (hs == H_ACK);
  assign calc_req     = (st == S_REQ);
  assign err          = (st == S_ERR);
  assign dbg_state    = st;
  assign dbg_hs_state = hs;

  always_comb begin
    case (st)
      S_ENTER_A:      display_value = operand_a;
      S_ENTER_B, S_REQ: display_value = operand_b;
      default:        display_value = '0;
    endcase
  end

endmodule

// File: tb/tb_key_entry_assembler.sv
// Directed bench for key_entry_assembler: keypad handshake, operand entry,
// overflow/error, REQ back-pressure and asynchronous reset.
module tb_key_entry_assembler;

  logic        clk;
  logic        RST;
  logic        KeyRdy;
  logic        KeyRd;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        calc_req;
  logic        calc_ack;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  calc_op;
  logic [15:0] display_value;
  logic        err;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_hs_state;

  int vectors = 0;
  int miscompares = 0;
  int pulses;
  bit seen;

  localparam logic [2:0] ADD = 3'b001, SUB = 3'b010, MUL = 3'b011, CLR = 3'b111;

  key_entry_assembler #(.MAX_DIGITS(5)) dut (
    .clk(clk), .RST(RST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .keypad_input(keypad_input), .operator_input(operator_input),
    .equal_input(equal_input), .calc_req(calc_req), .calc_ack(calc_ack),
    .operand_a(operand_a), .operand_b(operand_b), .calc_op(calc_op),
    .display_value(display_value), .err(err),
    .dbg_state(dbg_state), .dbg_hs_state(dbg_hs_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] kp, input logic [2:0] op, input logic eq);
    bit got = 1'b0;
    keypad_input = kp; operator_input = op; equal_input = eq; KeyRdy = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (KeyRd) got = 1'b1;
    end
    check("keyrd_seen", {31'b0, got}, 32'd1);
    KeyRdy = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] d); press(d, 3'b000, 1'b0); endtask
  task automatic oper(input logic [2:0] c); press(4'd0, c, 1'b0); endtask
  task automatic equal_key(); press(4'd0, 3'b000, 1'b1); endtask

  task automatic ack_once();
    calc_ack = 1'b1;
    @(posedge clk); #1;
    calc_ack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; KeyRdy = 1'b0; keypad_input = '0; operator_input = '0;
    equal_input = 1'b0; calc_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    check("rst_keyrd", KeyRd, 0);
    check("rst_req", calc_req, 0);
    check("rst_a", operand_a, 0);
    check("rst_b", operand_b, 0);
    check("rst_op", calc_op, 0);
    check("rst_disp", display_value, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);

    // 12 + 3 =
    digit(1); digit(2);
    check("t1_disp12", display_value, 12);
    oper(ADD);
    check("t1_state_b", dbg_state, 1);
    check("t1_op", calc_op, 1);
    digit(3); equal_key();
    check("t1_req", calc_req, 1);
    check("t1_a", operand_a, 12);
    check("t1_b", operand_b, 3);
    check("t1_op_req", calc_op, 1);
    check("t1_disp_req", display_value, 3);
    ack_once();
    check("t1_req_drop", calc_req, 0);
    check("t1_a_clr", operand_a, 0);
    check("t1_state_a", dbg_state, 0);

    // KeyRdy held high well past KeyRd: one consume only
    keypad_input = 4'd7; KeyRdy = 1'b1; pulses = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (KeyRd) pulses++;
    end
    KeyRdy = 1'b0; keypad_input = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t2_pulses", pulses, 1);
    check("t2_a", operand_a, 7);
    oper(CLR);
    check("t2_clr_a", operand_a, 0);

    // -32768 * -2 =
    oper(SUB); digit(3); digit(2); digit(7); digit(6); digit(8);
    check("t3_a", operand_a, 32'h8000);
    check("t3_disp", display_value, 32'h8000);
    check("t3_err_a", err, 0);
    oper(MUL); oper(SUB); digit(2); equal_key();
    check("t3_req", calc_req, 1);
    check("t3_b", operand_b, 32'hFFFE);
    check("t3_op", calc_op, 3);
    check("t3_err", err, 0);
    ack_once();

    // +32768 overflows
    digit(3); digit(2); digit(7); digit(6);
    check("t4_pre", operand_a, 3276);
    digit(8);
    check("t4_err", err, 1);
    check("t4_disp", display_value, 0);
    check("t4_state", dbg_state, 3);
    digit(1);
    check("t4_err_sticky", err, 1);
    oper(CLR);
    check("t4_err_clr", err, 0);
    check("t4_state_a", dbg_state, 0);
    check("t4_a", operand_a, 0);

    // Entry boundaries
    oper(ADD);
    check("b_add_no_digits", dbg_state, 0);
    check("b_op_unchanged", calc_op, 0);
    digit(1); digit(2); digit(3); digit(4); digit(5); digit(6);
    check("b_max_digits", operand_a, 12345);
    digit(4'd12);
    check("b_digit_gt9", operand_a, 12345);
    equal_key();
    check("b_eq_in_a", dbg_state, 0);
    oper(MUL);
    equal_key();
    check("b_eq_no_b", dbg_state, 1);
    oper(SUB); oper(ADD);
    check("b_op_replace", calc_op, 1);
    digit(4);
    check("b_b_neg", operand_b, 32'hFFFC);
    equal_key();
    check("b_req", calc_req, 1);

    // Back-pressure in REQ
    keypad_input = 4'd5; KeyRdy = 1'b1; pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (KeyRd) pulses++;
    end
    check("t5_no_keyrd", pulses, 0);
    check("t5_req_held", calc_req, 1);
    check("t5_a_held", operand_a, 12345);
    ack_once();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (KeyRd) seen = 1'b1;
    end
    check("t5_keyrd_after_ack", {31'b0, seen}, 1);
    KeyRdy = 1'b0; keypad_input = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_a", operand_a, 5);
    check("t5_state", dbg_state, 0);

    // Asynchronous reset inside H_ACK
    keypad_input = 4'd9; KeyRdy = 1'b1;
    @(posedge clk); #1;
    check("t6_keyrd", KeyRd, 1);
    check("t6_a59", operand_a, 59);
    #2 RST = 1'b1;
    #1;
    check("t6_keyrd_drop", KeyRd, 0);
    check("t6_req", calc_req, 0);
    check("t6_a", operand_a, 0);
    check("t6_hs", dbg_hs_state, 0);
    KeyRdy = 1'b0; keypad_input = '0;
    @(posedge clk); #1 RST = 1'b0;

    // Asynchronous reset inside REQ
    digit(1); oper(ADD); digit(2); equal_key();
    check("t6_req_up", calc_req, 1);
    #2 RST = 1'b1;
    #1;
    check("t6_req_drop", calc_req, 0);
    check("t6_b_zero", operand_b, 0);
    @(posedge clk); #1 RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
